sw_pe_affine_ext: RTL and testbench

- Parametrised next-generation Smith-Waterman systolic processing element with affine gaps: one query symbol per PE, database symbols stream through.
- Generalises alphabet width and score width, and uses signed saturating arithmetic.
- Replaces enable/lock with a valid/stall pipeline and adds runtime local/global mode.
- Tracks the running per-row maximum score and its column, and emits a row-max result at end of sequence.

---
 rtl/sw_pkg.sv | 34 +++
 rtl/sw_sat_max3.sv | 22 ++
 rtl/sw_pe_affine_ext.sv | 200 ++++++++++++++++++++
 tb/tb_sw_pe_affine_ext.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// Shared constants and signed saturating helpers for the Smith-Waterman PE.
// Helpers work on 32-bit signed values and clamp to a runtime score width.
package sw_pkg;

   localparam int SYM_W_DNA  = 2;
   localparam int SYM_W_PROT = 5;

   function automatic logic signed [31:0] score_max(input int w);
      return (32'sd1 <<< (w - 1)) - 32'sd1;
   endfunction

   function automatic logic signed [31:0] score_min(input int w);
      return -(32'sd1 <<< (w - 1));
   endfunction

   // Sum is formed one bit wider so it can never wrap before clamping.
   function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                  input logic signed [31:0] b,
                                                  input int w);
      logic signed [32:0] sum, hi, lo;
      sum = 33'(a) + 33'(b);
      hi  = 33'(score_max(w));
      lo  = 33'(score_min(w));
      if (sum > hi)      return score_max(w);
      else if (sum < lo) return score_min(w);
      else               return signed'(sum[31:0]);
   endfunction

   function automatic logic signed [31:0] smax(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sw_sat_max3.sv
// Combinational signed 3-input max with optional zero floor (local alignment).
module sw_sat_max3
   import sw_pkg::*;
#(
   parameter int W = 12
) (
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   input  logic signed [W-1:0] c,
   input  logic                floor_en,
   output logic signed [W-1:0] y
);

   logic signed [31:0] m;

   always_comb begin
      m = smax(smax(32'(a), 32'(b)), 32'(c));
      if (floor_en) m = smax(m, 32'sd0);
      y = W'(m);
   end

endmodule

// File: rtl/sw_pe_affine_ext.sv
// Affine-gap Smith-Waterman systolic PE: one query symbol, streaming database,
// valid/stall pipeline, local/global mode and per-row max/column reporting.
module sw_pe_affine_ext
   import sw_pkg::*;
#(
   parameter int SYM_W   = 2,
   parameter int SCORE_W = 12,
   parameter int COL_W   = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clear,
   input  logic                      stall,
   input  logic                      local_mode,
   input  logic [SYM_W-1:0]          s,
   input  logic signed [SCORE_W-1:0] match,
   input  logic signed [SCORE_W-1:0] mismatch,
   input  logic signed [SCORE_W-1:0] minus_alpha,
   input  logic signed [SCORE_W-1:0] minus_beta,
   input  logic                      in_valid,
   input  logic                      new_line_in,
   input  logic                      last_in,
   input  logic [SYM_W-1:0]          t_in,
   input  logic signed [SCORE_W-1:0] v_in,
   input  logic signed [SCORE_W-1:0] v_alpha_in,
   input  logic signed [SCORE_W-1:0] f_in,
   output logic                      out_valid,
   output logic                      new_line_out,
   output logic                      last_out,
   output logic [SYM_W-1:0]          t_out,
   output logic signed [SCORE_W-1:0] v_out,
   output logic signed [SCORE_W-1:0] v_alpha_out,
   output logic signed [SCORE_W-1:0] f_out,
   output logic signed [SCORE_W-1:0] row_max,
   output logic [COL_W-1:0]          row_col,
   output logic                      row_max_valid
);

   typedef logic signed [SCORE_W-1:0] score_t;

   function automatic score_t sat(input score_t a, input score_t b);
      return SCORE_W'(sat_add(32'(a), 32'(b), SCORE_W));
   endfunction

   function automatic score_t max2(input score_t a, input score_t b);
      return (a > b) ? a : b;
   endfunction

   logic             out_valid_q, out_valid_d, new_line_out_q, new_line_out_d;
   logic             last_out_q, last_out_d, row_max_valid_q, row_max_valid_d;
   logic [SYM_W-1:0] t_out_q, t_out_d;
   score_t           v_out_q, v_out_d, v_alpha_out_q, v_alpha_out_d, f_out_q, f_out_d;
   score_t           v_diag_q, v_diag_d, pre_e_q, pre_e_d, pre_v_alpha_q, pre_v_alpha_d;
   score_t           run_max_q, run_max_d, row_max_q, row_max_d;
   logic [COL_W-1:0] run_col_q, run_col_d, row_col_q, row_col_d, col_cnt_q, col_cnt_d;

   score_t           vd, pe, pva, diag, e_val, f_val, v_val, v_alpha_val, cand_max;
   logic [COL_W-1:0] col, cand_col;

   // First element of a row sees a virtual zero boundary row/column.
   always_comb begin
      vd          = new_line_in ? '0 : v_diag_q;
      pe          = new_line_in ? '0 : pre_e_q;
      pva         = new_line_in ? minus_alpha : pre_v_alpha_q;
      diag        = sat(vd, (s == t_in) ? match : mismatch);
      e_val       = max2(sat(pe, minus_beta), pva);
      f_val       = max2(v_alpha_in, sat(f_in, minus_beta));
      col         = new_line_in ? '0 : col_cnt_q;
      v_alpha_val = sat(v_val, minus_alpha);
      if (new_line_in || (v_val > run_max_q)) begin
         cand_max = v_val;
         cand_col = col;
      end else begin
         cand_max = run_max_q;
         cand_col = run_col_q;
      end
   end

   sw_sat_max3 #(.W(SCORE_W)) u_vmax (
      .a        (diag),
      .b        (e_val),
      .c        (f_val),
      .floor_en (local_mode),
      .y        (v_val)
   );

   always_comb begin
      out_valid_d     = out_valid_q;
      new_line_out_d  = new_line_out_q;
      last_out_d      = last_out_q;
      row_max_valid_d = row_max_valid_q;
      t_out_d         = t_out_q;
      v_out_d         = v_out_q;
      v_alpha_out_d   = v_alpha_out_q;
      f_out_d         = f_out_q;
      v_diag_d        = v_diag_q;
      pre_e_d         = pre_e_q;
      pre_v_alpha_d   = pre_v_alpha_q;
      run_max_d       = run_max_q;
      run_col_d       = run_col_q;
      row_max_d       = row_max_q;
      row_col_d       = row_col_q;
      col_cnt_d       = col_cnt_q;
      if (clear) begin
         out_valid_d     = 1'b0;
         new_line_out_d  = 1'b0;
         last_out_d      = 1'b0;
         row_max_valid_d = 1'b0;
         t_out_d         = '0;
         v_out_d         = '0;
         v_alpha_out_d   = '0;
         f_out_d         = '0;
         v_diag_d        = '0;
         pre_e_d         = '0;
         pre_v_alpha_d   = '0;
         run_max_d       = '0;
         run_col_d       = '0;
         row_max_d       = '0;
         row_col_d       = '0;
         col_cnt_d       = '0;
      end else if (!stall) begin
         if (in_valid) begin
            out_valid_d     = 1'b1;
            new_line_out_d  = new_line_in;
            last_out_d      = last_in;
            t_out_d         = t_in;
            v_out_d         = v_val;
            v_alpha_out_d   = v_alpha_val;
            f_out_d         = f_val;
            v_diag_d        = v_in;
            pre_e_d         = e_val;
            pre_v_alpha_d   = v_alpha_val;
            run_max_d       = cand_max;
            run_col_d       = cand_col;
            col_cnt_d       = col + COL_W'(1);
            row_max_valid_d = last_in;
            if (last_in) begin
               row_max_d = cand_max;
               row_col_d = cand_col;
            end
         end else begin
            // Bubble: flags drop, data and row state are held.
            out_valid_d     = 1'b0;
            new_line_out_d  = 1'b0;
            last_out_d      = 1'b0;
            row_max_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q     <= 1'b0;
         new_line_out_q  <= 1'b0;
         last_out_q      <= 1'b0;
         row_max_valid_q <= 1'b0;
         t_out_q         <= '0;
         v_out_q         <= '0;
         v_alpha_out_q   <= '0;
         f_out_q         <= '0;
         v_diag_q        <= '0;
         pre_e_q         <= '0;
         pre_v_alpha_q   <= '0;
         run_max_q       <= '0;
         run_col_q       <= '0;
         row_max_q       <= '0;
         row_col_q       <= '0;
         col_cnt_q       <= '0;
      end else begin
         out_valid_q     <= out_valid_d;
         new_line_out_q  <= new_line_out_d;
         last_out_q      <= last_out_d;
         row_max_valid_q <= row_max_valid_d;
         t_out_q         <= t_out_d;
         v_out_q         <= v_out_d;
         v_alpha_out_q   <= v_alpha_out_d;
         f_out_q         <= f_out_d;
         v_diag_q        <= v_diag_d;
         pre_e_q         <= pre_e_d;
         pre_v_alpha_q   <= pre_v_alpha_d;
         run_max_q       <= run_max_d;
         run_col_q       <= run_col_d;
         row_max_q       <= row_max_d;
         row_col_q       <= row_col_d;
         col_cnt_q       <= col_cnt_d;
      end
   end

   assign out_valid     = out_valid_q;
   assign new_line_out  = new_line_out_q;
   assign last_out      = last_out_q;
   assign t_out         = t_out_q;
   assign v_out         = v_out_q;
   assign v_alpha_out   = v_alpha_out_q;
   assign f_out         = f_out_q;
   assign row_max       = row_max_q;
   assign row_col       = row_col_q;
   assign row_max_valid = row_max_valid_q;

endmodule

// File: tb/tb_sw_pe_affine_ext.sv
// Directed bench for sw_pe_affine_ext: a 12-bit and a 6-bit instance share control.
module tb_sw_pe_affine_ext;

   logic clk = 1'b0, rst = 1'b1, clear = 1'b0, stall = 1'b0, local_mode = 1'b1;
   logic [1:0] s = '0, t_in = '0;
   logic in_valid = 1'b0, new_line_in = 1'b0, last_in = 1'b0;
   logic signed [11:0] match = '0, mismatch = '0, minus_alpha = '0, minus_beta = '0;
   logic signed [11:0] v_in = '0, v_alpha_in = '0, f_in = '0;
   logic out_valid, new_line_out, last_out, row_max_valid;
   logic [1:0] t_out;
   logic signed [11:0] v_out, v_alpha_out, f_out, row_max;
   logic [15:0] row_col;

   logic signed [5:0] match6 = '0, mismatch6 = '0, alpha6 = '0, beta6 = '0;
   logic signed [5:0] v_in6 = '0, va_in6 = '0, f_in6 = '0;
   logic out_valid6, new_line_out6, last_out6, row_max_valid6;
   logic [1:0] t_out6;
   logic signed [5:0] v_out6, v_alpha_out6, f_out6, row_max6;
   logic [15:0] row_col6;

   int n_tests = 0, n_fail = 0;

   always #5 clk = ~clk;

   sw_pe_affine_ext #(.SYM_W(2), .SCORE_W(12), .COL_W(16)) u_dut (
      .clk(clk), .rst(rst), .clear(clear), .stall(stall), .local_mode(local_mode),
      .s(s), .match(match), .mismatch(mismatch), .minus_alpha(minus_alpha),
      .minus_beta(minus_beta), .in_valid(in_valid), .new_line_in(new_line_in),
      .last_in(last_in), .t_in(t_in), .v_in(v_in), .v_alpha_in(v_alpha_in), .f_in(f_in),
      .out_valid(out_valid), .new_line_out(new_line_out), .last_out(last_out),
      .t_out(t_out), .v_out(v_out), .v_alpha_out(v_alpha_out), .f_out(f_out),
      .row_max(row_max), .row_col(row_col), .row_max_valid(row_max_valid));

   sw_pe_affine_ext #(.SYM_W(2), .SCORE_W(6), .COL_W(16)) u_dut6 (
      .clk(clk), .rst(rst), .clear(clear), .stall(stall), .local_mode(local_mode),
      .s(s), .match(match6), .mismatch(mismatch6), .minus_alpha(alpha6),
      .minus_beta(beta6), .in_valid(in_valid), .new_line_in(new_line_in),
      .last_in(last_in), .t_in(t_in), .v_in(v_in6), .v_alpha_in(va_in6), .f_in(f_in6),
      .out_valid(out_valid6), .new_line_out(new_line_out6), .last_out(last_out6),
      .t_out(t_out6), .v_out(v_out6), .v_alpha_out(v_alpha_out6), .f_out(f_out6),
      .row_max(row_max6), .row_col(row_col6), .row_max_valid(row_max_valid6));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic elem(input logic nl, input logic last, input logic [1:0] t,
                       input int vi, input int va, input int fi);
      in_valid = 1'b1; new_line_in = nl; last_in = last; t_in = t;
      v_in = 12'(vi); v_alpha_in = 12'(va); f_in = 12'(fi);
      step();
      in_valid = 1'b0; new_line_in = 1'b0; last_in = 1'b0;
   endtask

   task automatic set_scores(input int m, input int mm, input int a, input int b);
      match = 12'(m); mismatch = 12'(mm); minus_alpha = 12'(a); minus_beta = 12'(b);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      n_tests++;
      if ({out_valid, new_line_out, last_out, row_max_valid} !== 4'b0 || v_out !== 12'sd0 ||
          f_out !== 12'sd0 || v_alpha_out !== 12'sd0 || row_max !== 12'sd0 || row_col !== 16'd0) begin
         n_fail++; $display("FAIL reset_state: v_out=%0d f_out=%0d valid=%b want all 0", v_out, f_out, out_valid);
      end
      set_scores(2, -1, -3, -1); local_mode = 1'b1; s = 2'd0;
      elem(1'b1, 1'b0, 2'd0, 0, -3, 0);
      n_tests++;
      if (v_out !== 12'sd2 || out_valid !== 1'b1) begin
         n_fail++; $display("FAIL pre_reset_elem: v_out=%0d valid=%b want 2/1", v_out, out_valid);
      end
      rst = 1'b1;
      #1;
      n_tests++;
      if (v_out !== 12'sd0 || out_valid !== 1'b0 || f_out !== 12'sd0) begin
         n_fail++; $display("FAIL async_reset: v_out=%0d valid=%b want 0/0", v_out, out_valid);
      end
      #2 rst = 1'b0;
      step();
      n_tests++;
      if (v_out !== 12'sd0 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL after_reset_release: v_out=%0d valid=%b want 0/0", v_out, out_valid);
      end
   endtask

   task automatic test_match_chain();
      set_scores(2, -1, -3, -1); local_mode = 1'b1; s = 2'd0;
      elem(1'b1, 1'b0, 2'd0, 0, -3, 0);
      n_tests++;
      if (v_out !== 12'sd2 || f_out !== -12'sd1 || v_alpha_out !== -12'sd1 || new_line_out !== 1'b1) begin
         n_fail++; $display("FAIL chain_e1: v=%0d f=%0d va=%0d nl=%b want 2/-1/-1/1", v_out, f_out, v_alpha_out, new_line_out);
      end
      elem(1'b0, 1'b1, 2'd0, 0, -3, 0);
      n_tests++;
      if (v_out !== 12'sd2 || last_out !== 1'b1 || row_max_valid !== 1'b1) begin
         n_fail++; $display("FAIL chain_e2: v=%0d last=%b strobe=%b want 2/1/1", v_out, last_out, row_max_valid);
      end
      n_tests++;
      if (row_max !== 12'sd2 || row_col !== 16'd0) begin
         n_fail++; $display("FAIL chain_tie: row_max=%0d row_col=%0d want 2/0", row_max, row_col);
      end
      step();
      n_tests++;
      if (row_max_valid !== 1'b0 || out_valid !== 1'b0 || row_max !== 12'sd2 || v_out !== 12'sd2) begin
         n_fail++; $display("FAIL chain_after: strobe=%b valid=%b row_max=%0d v=%0d want 0/0/2/2", row_max_valid, out_valid, row_max, v_out);
      end
   endtask

   task automatic test_clear();
      elem(1'b1, 1'b0, 2'd0, 0, -3, 0);
      clear = 1'b1; stall = 1'b1; in_valid = 1'b1; new_line_in = 1'b1;
      step();
      clear = 1'b0; stall = 1'b0; in_valid = 1'b0; new_line_in = 1'b0;
      n_tests++;
      if (v_out !== 12'sd0 || f_out !== 12'sd0 || v_alpha_out !== 12'sd0 || out_valid !== 1'b0 ||
          row_max !== 12'sd0 || row_max_valid !== 1'b0) begin
         n_fail++; $display("FAIL clear_over_stall: v=%0d f=%0d va=%0d row_max=%0d want all 0", v_out, f_out, v_alpha_out, row_max);
      end
   endtask

   task automatic test_local_global();
      set_scores(2, -1, -3, -1); s = 2'd0;
      local_mode = 1'b1;
      elem(1'b1, 1'b0, 2'd1, 0, -3, -5);
      n_tests++;
      if (v_out !== 12'sd0) begin
         n_fail++; $display("FAIL local_floor: v=%0d want 0", v_out);
      end
      local_mode = 1'b0;
      elem(1'b1, 1'b0, 2'd1, 0, -3, -5);
      n_tests++;
      if (v_out !== -12'sd1 || f_out !== -12'sd3) begin
         n_fail++; $display("FAIL global_nofloor: v=%0d f=%0d want -1/-3", v_out, f_out);
      end
   endtask

   task automatic test_saturation();
      local_mode = 1'b0; s = 2'd0;
      match6 = 6'sd20; mismatch6 = -6'sd1; alpha6 = -6'sd3; beta6 = -6'sd1;
      v_in6 = 6'sd31; va_in6 = -6'sd3; f_in6 = 6'sd0;
      elem(1'b1, 1'b0, 2'd0, 0, 0, 0);
      n_tests++;
      if (v_out6 !== 6'sd20 || v_alpha_out6 !== 6'sd17) begin
         n_fail++; $display("FAIL sat_e1: v=%0d va=%0d want 20/17", v_out6, v_alpha_out6);
      end
      elem(1'b0, 1'b0, 2'd0, 0, 0, 0);
      n_tests++;
      if (v_out6 !== 6'sd31 || v_alpha_out6 !== 6'sd28) begin
         n_fail++; $display("FAIL sat_high: v=%0d va=%0d want 31/28", v_out6, v_alpha_out6);
      end
      match6 = -6'sd32; mismatch6 = -6'sd32; alpha6 = -6'sd32; beta6 = -6'sd32;
      v_in6 = -6'sd32; va_in6 = -6'sd32; f_in6 = -6'sd32;
      elem(1'b1, 1'b0, 2'd1, 0, 0, 0);
      n_tests++;
      if (v_out6 !== -6'sd32 || v_alpha_out6 !== -6'sd32 || f_out6 !== -6'sd32) begin
         n_fail++; $display("FAIL sat_low: v=%0d va=%0d f=%0d want -32", v_out6, v_alpha_out6, f_out6);
      end
      elem(1'b0, 1'b0, 2'd1, 0, 0, 0);
      n_tests++;
      if (v_out6 !== -6'sd32 || v_alpha_out6 !== -6'sd32) begin
         n_fail++; $display("FAIL sat_low_row: v=%0d va=%0d want -32/-32", v_out6, v_alpha_out6);
      end
   endtask

   // V sequence 1,4,3,4 is steered through v_alpha_in with diag and E kept below it.
   task automatic test_max_pos();
      set_scores(5, -10, -3, -1); local_mode = 1'b0; s = 2'd0;
      elem(1'b1, 1'b0, 2'd1, -50, 1, -100);
      n_tests++;
      if (v_out !== 12'sd1) begin n_fail++; $display("FAIL maxpos_v1: v=%0d want 1", v_out); end
      elem(1'b0, 1'b0, 2'd1, -50, 4, -100);
      n_tests++;
      if (v_out !== 12'sd4) begin n_fail++; $display("FAIL maxpos_v2: v=%0d want 4", v_out); end
      elem(1'b0, 1'b0, 2'd1, -50, 3, -100);
      n_tests++;
      if (v_out !== 12'sd3 || row_max_valid !== 1'b0) begin
         n_fail++; $display("FAIL maxpos_v3: v=%0d strobe=%b want 3/0", v_out, row_max_valid);
      end
      elem(1'b0, 1'b1, 2'd1, -50, 4, -100);
      n_tests++;
      if (v_out !== 12'sd4 || row_max !== 12'sd4 || row_col !== 16'd1 || row_max_valid !== 1'b1) begin
         n_fail++; $display("FAIL maxpos_result: v=%0d row_max=%0d col=%0d strobe=%b want 4/4/1/1", v_out, row_max, row_col, row_max_valid);
      end
      step();
   endtask

   task automatic test_stall_bubble();
      set_scores(5, -10, -3, -1); local_mode = 1'b0; s = 2'd0;
      elem(1'b1, 1'b0, 2'd1, -50, 1, -100);
      elem(1'b0, 1'b0, 2'd1, -50, 4, -100);
      stall = 1'b1; in_valid = 1'b1; t_in = 2'd1; v_alpha_in = 12'sd3;
      for (int i = 0; i < 3; i++) step();
      n_tests++;
      if (v_out !== 12'sd4 || out_valid !== 1'b1) begin
         n_fail++; $display("FAIL stall_hold: v=%0d valid=%b want 4/1", v_out, out_valid);
      end
      stall = 1'b0;
      elem(1'b0, 1'b0, 2'd1, -50, 3, -100);
      n_tests++;
      if (v_out !== 12'sd3) begin n_fail++; $display("FAIL stall_v3: v=%0d want 3", v_out); end
      step();
      step();
      n_tests++;
      if (out_valid !== 1'b0 || v_out !== 12'sd3 || row_max_valid !== 1'b0) begin
         n_fail++; $display("FAIL bubble_hold: valid=%b v=%0d strobe=%b want 0/3/0", out_valid, v_out, row_max_valid);
      end
      elem(1'b0, 1'b1, 2'd1, -50, 4, -100);
      n_tests++;
      if (v_out !== 12'sd4 || row_max !== 12'sd4 || row_col !== 16'd1 || row_max_valid !== 1'b1) begin
         n_fail++; $display("FAIL stall_result: v=%0d row_max=%0d col=%0d strobe=%b want 4/4/1/1", v_out, row_max, row_col, row_max_valid);
      end
      stall = 1'b1;
      step();
      step();
      n_tests++;
      if (row_max_valid !== 1'b1) begin
         n_fail++; $display("FAIL strobe_stalled: strobe=%b want 1", row_max_valid);
      end
      stall = 1'b0;
      step();
      n_tests++;
      if (row_max_valid !== 1'b0 || row_max !== 12'sd4 || row_col !== 16'd1) begin
         n_fail++; $display("FAIL strobe_drop: strobe=%b row_max=%0d col=%0d want 0/4/1", row_max_valid, row_max, row_col);
      end
   endtask

   task automatic test_one_column();
      set_scores(2, -1, -3, -1); local_mode = 1'b1; s = 2'd0;
      elem(1'b1, 1'b1, 2'd0, 0, -3, 0);
      n_tests++;
      if (row_max !== 12'sd2 || row_col !== 16'd0 || row_max_valid !== 1'b1) begin
         n_fail++; $display("FAIL one_column: row_max=%0d col=%0d strobe=%b want 2/0/1", row_max, row_col, row_max_valid);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_match_chain();
      test_clear();
      test_local_global();
      test_saturation();
      test_max_pos();
      test_stall_bubble();
      test_one_column();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
